stopwatch_ctrl: RTL

- Control FSM and timebase for the lab stopwatch.
- Replaces free-running toggled-clock division with a single-clock tick enable: prescales `clk` to a 10 ms tick and counts SS.cc in BCD.
- Sequences run, pause, clear and lap-freeze from three raw push-buttons.
- Feeds the 4-digit display scanner with a registered 16-bit BCD word.

---
 rtl/stopwatch_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, run/pause/lap FSM,
// centisecond tick prescaler and SS.cc BCD counter.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_clr,
  input  logic        btn_lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        frozen,
  output logic        tick,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]         btn_w;
  logic [2:0]         s1_q, s2_q;
  logic [2:0]         acc_q, acc_d;
  logic [2:0]         arm_q, arm_d;
  logic [2:0]         ev_q, ev_d;
  logic [2:0][DW-1:0] db_q, db_d;
  logic [1:0]         warm_q, warm_d;

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;

  logic ss_ev, clr_ev, lap_ev;
  logic act, clr_now;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = v;
    if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        if (d2 != 4'd9) begin
          d2 = d2 + 4'd1;
        end else begin
          d2 = 4'd0;
          d3 = (d3 == 4'd5) ? 4'd0 : d3 + 4'd1;
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  assign btn_w = {btn_lap, btn_clr, btn_ss};

  // A button must be seen low after reset before it may fire,
  // so a button held through reset never yields an event.
  always_comb begin
    warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    db_d   = db_q;
    acc_d  = acc_q;
    arm_d  = arm_q;
    ev_d   = '0;
    for (int i = 0; i < 3; i++) begin
      arm_d[i] = arm_q[i] | (warm_q == 2'd2 && !s2_q[i]);
      if (s2_q[i] == acc_q[i]) begin
        db_d[i] = '0;
      end else if (db_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = '0;
        acc_d[i] = s2_q[i];
        ev_d[i]  = s2_q[i] & arm_q[i];
      end else begin
        db_d[i] = db_q[i] + DW'(1);
      end
    end
  end

  assign ss_ev  = ev_q[0];
  assign clr_ev = ev_q[1] & ~ev_q[0];
  assign lap_ev = ev_q[2] & ~ev_q[1] & ~ev_q[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ss_ev) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_ev)       state_d = S_PAUSE;
        else if (lap_ev) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_ev)       state_d = S_PAUSE;
        else if (lap_ev) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_ev)       state_d = S_RUN;
        else if (clr_ev) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign act     = (state_q == S_RUN) || (state_q == S_LAP);
  assign clr_now = (state_q == S_PAUSE) && (state_d == S_IDLE);
  assign tick    = act && (pre_q == PW'(TICK_DIV - 1));
  assign wrap    = tick && (cnt_q == 16'h5999);

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    disp_d = cnt_q;
    if (state_q == S_IDLE || clr_now) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (act) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) cnt_d = bcd_inc(cnt_q);
    end
    // Staying in LAP keeps the snapshot taken on entry.
    if (state_q == S_LAP && state_d == S_LAP) disp_d = disp_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      acc_q   <= '0;
      arm_q   <= '0;
      ev_q    <= '0;
      db_q    <= '0;
      warm_q  <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= btn_w;
      s2_q    <= s1_q;
      acc_q   <= acc_d;
      arm_q   <= arm_d;
      ev_q    <= ev_d;
      db_q    <= db_d;
      warm_q  <= warm_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  assign disp    = disp_q;
  assign running = act;
  assign frozen  = (state_q == S_LAP);

endmodule
